// File: rtl/seq_player.sv
// seq_player: plays back a pseudo-random sequence of 4-way symbols for a memory game.
//
// Each game is seeded from a free-running counter sampled on clear. Playback of round L
// shows the first L outputs of a 16-bit Galois LFSR (mask 16'hB400) started from that seed,
// so every round replays the previous one as a prefix and adds one symbol.
//
// Optional feature macro: SEQ_PLAYER_GAP_EN
//   defined   : symbols are separated by TICKS_OFF blank cycles (GAP state).
//   undefined : no GAP state; symbols are shown back to back and TICKS_OFF only sizes the
//               timer.
//
// Ports:
//   clock      in   rising-edge system clock
//   reset      in   synchronous, active-high reset (priority over everything)
//   clear      in   new game: reseed, round_len <= 1, FSM to IDLE
//   start      in   level play request; dropping it aborts playback
//   next       in   single-cycle pulse, grow round_len (saturates at MAX_ROUNDS)
//   led        out  one-hot current symbol while lit, 0 when blank
//   sym        out  index of the current symbol (lfsr[1:0])
//   end_fpga   out  playback complete (DONE state)
//   round_len  out  current sequence length
//   win        out  round_len == MAX_ROUNDS
module seq_player #(
  parameter int unsigned MAX_ROUNDS = 16,
  parameter int unsigned TICKS_ON   = 25000000,
  parameter int unsigned TICKS_OFF  = 12500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       start,
  input  logic       next,
  output logic [3:0] led,
  output logic [1:0] sym,
  output logic       end_fpga,
  output logic [4:0] round_len,
  output logic       win
);

  localparam logic [15:0] LfsrMask = 16'hB400;
  localparam logic [15:0] LfsrInit = 16'hACE1;

  // One timer serves both SHOW and GAP, so it is sized for the longer of the two.
  localparam int unsigned TimerSpan = (TICKS_ON > TICKS_OFF) ? TICKS_ON : TICKS_OFF;
  localparam int unsigned TimerW    = (TimerSpan > 1) ? $clog2(TimerSpan) : 1;

`ifdef SEQ_PLAYER_GAP_EN
  typedef enum logic [1:0] {StIdle, StShow, StGap, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShow, StDone} state_e;
`endif

  state_e state_q, state_d;

  logic [15:0]       lfsr_q, lfsr_d;
  logic [15:0]       seed_q, seed_d;
  logic [15:0]       free_q, free_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [4:0]        idx_q, idx_d;
  logic [4:0]        round_len_q, round_len_d;

  logic        on_done;
  logic        last_sym;
  logic [15:0] lfsr_step;

  assign on_done  = (timer_q == TimerW'(TICKS_ON - 1));
  assign last_sym = (idx_q == (round_len_q - 5'd1));
  // Galois step: shift right, fold the mask in when a 1 falls out.
  assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrMask : 16'h0000);

`ifdef SEQ_PLAYER_GAP_EN
  logic off_done;
  assign off_done = (timer_q == TimerW'(TICKS_OFF - 1));
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) state_d = StShow;
        end
        StShow: begin
          if (!start) begin
            state_d = StIdle;
          end else if (on_done) begin
            if (last_sym) begin
              state_d = StDone;
            end else begin
`ifdef SEQ_PLAYER_GAP_EN
              state_d = StGap;
`else
              state_d = StShow;
`endif
            end
          end
        end
`ifdef SEQ_PLAYER_GAP_EN
        StGap: begin
          if (!start) begin
            state_d = StIdle;
          end else if (off_done) begin
            state_d = StShow;
          end
        end
`endif
        StDone: begin
          if (!start) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs decoded from state (lfsr is registered).
  always_comb begin
    led      = 4'b0000;
    end_fpga = 1'b0;
    unique case (state_q)
      StShow:  led = 4'b0001 << lfsr_q[1:0];
      StDone:  end_fpga = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: free counter, seed, round length, playback registers.
  always_comb begin
    free_d      = free_q + 16'd1;
    seed_d      = seed_q;
    round_len_d = round_len_q;
    lfsr_d      = lfsr_q;
    timer_d     = timer_q;
    idx_d       = idx_q;

    if (clear) begin
      // Forcing bit 0 keeps the LFSR out of its all-zero lock-up state.
      seed_d      = free_q | 16'h0001;
      round_len_d = 5'd1;
      timer_d     = '0;
    end else begin
      if (next && (round_len_q < 5'(MAX_ROUNDS))) begin
        round_len_d = round_len_q + 5'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            lfsr_d  = seed_q;
            idx_d   = 5'd0;
            timer_d = '0;
          end
        end
        StShow: begin
          if (start) begin
            if (on_done) begin
              lfsr_d  = lfsr_step;
              timer_d = '0;
              if (!last_sym) idx_d = idx_q + 5'd1;
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
        end
`ifdef SEQ_PLAYER_GAP_EN
        StGap: begin
          if (start) begin
            if (off_done) begin
              timer_d = '0;
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      free_q      <= 16'h0000;
      seed_q      <= LfsrInit;
      round_len_q <= 5'd1;
      lfsr_q      <= LfsrInit;
      timer_q     <= '0;
      idx_q       <= 5'd0;
    end else begin
      free_q      <= free_d;
      seed_q      <= seed_d;
      round_len_q <= round_len_d;
      lfsr_q      <= lfsr_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
    end
  end

  assign sym       = lfsr_q[1:0];
  assign round_len = round_len_q;
  assign win       = (round_len_q == 5'(MAX_ROUNDS));

endmodule

// File: tb/tb_seq_player.sv
// Directed bench for seq_player with TICKS_ON=4, TICKS_OFF=2, MAX_ROUNDS=16.
// Expected led sequences follow the LFSR from seed 16'hACE1:
//   ACE1 (sym 1) -> E270 (sym 0) -> 7138 (sym 0).
// Covers both builds: with SEQ_PLAYER_GAP_EN the symbols are separated by 2 blank cycles.
module tb_seq_player;

  logic       clock;
  logic       reset;
  logic       clear;
  logic       start;
  logic       next;
  logic [3:0] led;
  logic [1:0] sym;
  logic       end_fpga;
  logic [4:0] round_len;
  logic       win;

  int checks;
  int failures;

  seq_player #(
    .MAX_ROUNDS(16),
    .TICKS_ON  (4),
    .TICKS_OFF (2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .start    (start),
    .next     (next),
    .led      (led),
    .sym      (sym),
    .end_fpga (end_fpga),
    .round_len(round_len),
    .win      (win)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expected {end_fpga, led} at cycle c (1-based) of a round-3 playback from seed ACE1.
  function automatic logic [4:0] exp_round3(input int c);
`ifdef SEQ_PLAYER_GAP_EN
    if (c >= 17) return 5'b10000;
    if (((c - 1) % 6) >= 4) return 5'b00000;
    return (((c - 1) / 6) == 0) ? 5'b00010 : 5'b00001;
`else
    if (c >= 13) return 5'b10000;
    return (((c - 1) / 4) == 0) ? 5'b00010 : 5'b00001;
`endif
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    clear    = 1'b0;
    start    = 1'b0;
    next     = 1'b0;

    // Reset state.
    step();
    step();
    check_eq("rst_led", led, 4'b0000);
    check_eq("rst_end", end_fpga, 1'b0);
    check_eq("rst_round_len", round_len, 5'd1);
    check_eq("rst_win", win, 1'b0);
    reset = 1'b0;
    step();

    // Round 1: one symbol lit for 4 cycles, then DONE.
    start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      check_eq($sformatf("r1_lit_c%0d", c), {end_fpga, led}, 5'b00010);
    end
    check_eq("r1_sym", sym, 2'd1);
    step();
    check_eq("r1_done", {end_fpga, led}, 5'b10000);
    step();
    check_eq("r1_done_hold", end_fpga, 1'b1);
    start = 1'b0;
    step();
    check_eq("r1_idle", {end_fpga, led}, 5'b00000);

    // Two next pulses -> round_len 3.
    for (int i = 0; i < 2; i++) begin
      next = 1'b1;
      step();
      next = 1'b0;
      step();
    end
    check_eq("rl_after_2_next", round_len, 5'd3);

    // Round 3 playback.
    start = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      step();
      if (c <= 13 || exp_round3(13) != 5'b10000) begin
        check_eq($sformatf("r3_c%0d", c), {end_fpga, led}, exp_round3(c));
      end
    end
    start = 1'b0;
    step();
    check_eq("r3_idle", {end_fpga, led}, 5'b00000);

    // Abort during the 2nd SHOW cycle, then replay from the first symbol.
    start = 1'b1;
    step();
    step();
    check_eq("abort_show_c2", led, 4'b0010);
    start = 1'b0;
    step();
    check_eq("abort_blank", {end_fpga, led}, 5'b00000);
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      check_eq($sformatf("replay_c%0d", c), {end_fpga, led}, exp_round3(c));
    end
    start = 1'b0;
    step();

    // Saturation of round_len at 16.
    for (int i = 1; i <= 20; i++) begin
      next = 1'b1;
      step();
      next = 1'b0;
      check_eq($sformatf("sat_rl_%0d", i), round_len, ((3 + i) > 16) ? 5'd16 : 5'(3 + i));
      check_eq($sformatf("sat_win_%0d", i), win, ((3 + i) >= 16) ? 1'b1 : 1'b0);
      step();
    end

    // Clear overrides a simultaneous next; new seed is odd.
    clear = 1'b1;
    next  = 1'b1;
    step();
    clear = 1'b0;
    next  = 1'b0;
    check_eq("clr_round_len", round_len, 5'd1);
    check_eq("clr_win", win, 1'b0);
    start = 1'b1;
    step();
    check_eq("seed_odd_sym", sym[0], 1'b1);
    check_eq("seed_odd_led", |(led & 4'b1010), 1'b1);

    // Clear during SHOW forces IDLE.
    clear = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b0;
    check_eq("clr_show_blank", {end_fpga, led}, 5'b00000);
    step();

    // Reset has priority over start and next.
    next  = 1'b1;
    start = 1'b1;
    reset = 1'b1;
    step();
    check_eq("rst_prio_rl", round_len, 5'd1);
    check_eq("rst_prio_led", {end_fpga, led}, 5'b00000);
    reset = 1'b0;
    next  = 1'b0;
    start = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_player.md
SEQ_PLAYER -- requirements
Module: seq_player

Interface
REQ-001 The block SHALL have parameter MAX_ROUNDS, default 16, the maximum sequence length in symbols (range 2..31).
REQ-002 The block SHALL have parameter TICKS_ON, default 25000000, the clock cycles each symbol is lit (range 1 or more).
REQ-003 The block SHALL have parameter TICKS_OFF, default 12500000, the blank clock cycles between symbols (range 1 or more).
REQ-004 Port clock: input, 1 bit, rising-edge system clock.
REQ-005 Port reset: input, 1 bit, reset, synchronous, active-high.
REQ-006 Port clear: input, 1 bit, new-game clear (driven by controller r1).
REQ-007 Port start: input, 1 bit, level, play request (driven by controller e3).
REQ-008 Port next: input, 1 bit, single-cycle pulse, advance to the next round.
REQ-009 Port led: output, 4 bits, one-hot display of the current symbol; 0 when blank.
REQ-010 Port sym: output, 2 bits, index of the current symbol.
REQ-011 Port end_fpga: output, 1 bit, playback complete (to controller).
REQ-012 Port round_len: output, 5 bits, current sequence length.
REQ-013 Port win: output, 1 bit, high when round_len equals MAX_ROUNDS (to controller).

Function
REQ-014 The block SHALL run a free 16-bit counter, incremented every cycle.
REQ-015 On clear, the block SHALL set seed to (free counter OR 16'h0001), set round_len to 1, and force the FSM to IDLE; this applies from any state.
REQ-016 The block SHALL generate symbols with a 16-bit Galois LFSR, mask 16'hB400: shift right, XOR the mask when the shifted-out bit is 1; sym = lfsr[1:0].
REQ-017 The FSM SHALL have the states IDLE, SHOW, GAP and DONE, all registered.
REQ-018 IDLE: led=0, end_fpga=0; when start=1, load lfsr<=seed, idx<=0, timer<=0 and go to SHOW.
REQ-019 SHOW: led=onehot(sym); the timer counts 0..TICKS_ON-1; at TICKS_ON-1, step lfsr, reset the timer, then go to DONE if idx==round_len-1, otherwise idx++ and go to GAP.
REQ-020 GAP: led=0; the timer counts 0..TICKS_OFF-1, then goes to SHOW.
REQ-021 DONE: end_fpga=1, led=0; hold while start=1; when start=0, go to IDLE next cycle.
REQ-022 If start=0 in SHOW or GAP, the FSM SHALL go to IDLE next cycle with led=0; a later start SHALL replay from the first symbol.
REQ-023 next SHALL increment round_len, saturating at MAX_ROUNDS; clear SHALL override a simultaneous next.
REQ-024 win SHALL be combinational from registered round_len; all other outputs SHALL be registered or decoded from state only.
REQ-025 Playback of length L SHALL be deterministic: it is the first L LFSR outputs from seed, so each round replays the previous round as a prefix.

Reset
REQ-026 On reset, the block SHALL set state=IDLE, led=0, end_fpga=0, round_len=1, seed=16'hACE1, free counter=0, timer=0, idx=0.
REQ-027 Reset SHALL have priority over clear, next and start.

Configuration
REQ-028 With macro SEQ_PLAYER_GAP_EN defined, GAP SHALL be used as described in REQ-019 and REQ-020.
REQ-029 With SEQ_PLAYER_GAP_EN undefined, GAP and its timer compare SHALL be absent: SHOW goes directly to SHOW with idx++, and TICKS_OFF is ignored.

Verification (TICKS_ON=4, TICKS_OFF=2, MAX_ROUNDS=16 unless stated; GAP_EN defined)
REQ-030 Reset for 2 cycles -> led=0, end_fpga=0, round_len=1, win=0.
REQ-031 After reset, hold start=1 -> led=4'b0010 (seed 16'hACE1, sym=1) for 4 cycles, then end_fpga=1 on the 5th cycle after start is sampled; drop start -> IDLE next cycle.
REQ-032 After 2 next pulses (round_len=3), hold start -> 3x4 SHOW cycles plus 2x2 blank GAP cycles, end_fpga at cycle 17; the first symbol equals the round-1 symbol.
REQ-033 Drop start during the 2nd cycle of SHOW -> led=0 next cycle; raise start again -> the same first symbol and a full 4-cycle SHOW.
REQ-034 Send 20 next pulses -> round_len saturates at 16, win=1; pulse clear and next together -> round_len=1, win=0, seed odd.
REQ-035 With SEQ_PLAYER_GAP_EN undefined and round_len=3 -> 12 consecutive lit cycles, no blank cycle, end_fpga at cycle 13.
